// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined vector adder.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Returns 0 for an illegal split so the top level can refuse to elaborate.
  function automatic int calc_nseg(input int width, input int seg_w);
    if (seg_w < 1 || width < seg_w || (width % seg_w) != 0) return 0;
    return width / seg_w;
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG_W-bit ripple segment built from full_adder cells.
// Also exposes the carry into the segment MSB for signed-overflow detection.
module seg_adder #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_vector_adder.sv
// WIDTH-bit add/subtract pipelined as NSEG ripple segments with a registered
// carry between segments and a valid/ready handshake with full backpressure.
module pipelined_vector_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if (NSEG == 0) begin : g_bad_params
    $error("pipelined_vector_adder: WIDTH must be a positive multiple of SEG_W");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [NSEG-1:0]  valid_q;

  assign out_valid = valid_q[NSEG-1];
  assign advance   = !valid_q[NSEG-1] || out_ready;
  assign in_ready  = advance;
  assign b_eff     = (sub == SUB) ? ~b : b;
  assign c0        = (sub == SUB) ? 1'b1 : cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) valid_q[k] <= valid_q[k-1];
    end
  end

  // Stage k owns sum bits [DONE-1:0] plus the operand bits above DONE that
  // later stages still need, so storage shrinks/grows triangularly.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO   = k * SEG_W;
    localparam int DONE = LO + SEG_W;

    logic [WIDTH-LO-1:0] src_a;
    logic [WIDTH-LO-1:0] src_b;
    logic                src_carry;
    logic                src_valid;
    logic [SEG_W-1:0]    seg_s;
    logic                seg_cout;
    logic                seg_cmsb;
    logic [DONE-1:0]     sum_d;
    logic [DONE-1:0]     sum_q;
    logic                carry_q;

    if (k == 0) begin : g_src
      assign src_a     = a;
      assign src_b     = b_eff;
      assign src_carry = c0;
      assign src_valid = in_valid;
      assign sum_d     = seg_s;
    end else begin : g_src
      assign src_a     = g_stage[k-1].g_hi.a_hi_q;
      assign src_b     = g_stage[k-1].g_hi.b_hi_q;
      assign src_carry = g_stage[k-1].carry_q;
      assign src_valid = valid_q[k-1];
      assign sum_d     = {seg_s, g_stage[k-1].sum_q};
    end

    seg_adder #(.SEG_W(SEG_W)) u_seg (
      .a       (src_a[SEG_W-1:0]),
      .b       (src_b[SEG_W-1:0]),
      .cin     (src_carry),
      .s       (seg_s),
      .cout    (seg_cout),
      .c_msb_in(seg_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (advance && src_valid) begin
        sum_q   <= sum_d;
        carry_q <= seg_cout;
      end
    end

    if (k < NSEG - 1) begin : g_hi
      logic [WIDTH-DONE-1:0] a_hi_q;
      logic [WIDTH-DONE-1:0] b_hi_q;
      logic                  unused_cmsb;

      assign unused_cmsb = seg_cmsb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (advance && src_valid) begin
          a_hi_q <= src_a[WIDTH-LO-1:SEG_W];
          b_hi_q <= src_b[WIDTH-LO-1:SEG_W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (advance && src_valid) ovf_q <= seg_cmsb ^ seg_cout;
      end

      assign s    = sum_q;
      assign cout = carry_q;
      assign ovf  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_vector_adder.sv
// Scoreboard bench: a directed 16/4 instance plus randomized (8,8), (32,4) and
// (12,3) instances, all checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_vector_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          age;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Plain integer arithmetic: returns {ovf, cout, s}.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci,
                                            input logic sb);
    longint modv, ux, uy, sx, sy, full, sfull;
    logic co, ov;
    modv = longint'(1) << w;
    ux   = longint'(x);
    uy   = longint'(y);
    sx   = (ux >= modv / 2) ? ux - modv : ux;
    sy   = (uy >= modv / 2) ? uy - modv : uy;
    if (sb) begin
      full  = ux - uy;
      co    = (ux >= uy);
      sfull = sx - sy;
    end else begin
      full  = ux + uy + longint'(ci);
      co    = (full >= modv);
      sfull = sx + sy + longint'(ci);
    end
    ov = (sfull >= modv / 2) || (sfull < -(modv / 2));
    return {ov, co, 32'(full & (modv - 1))};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W  = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 32 : 12;
    localparam int SW = (g == 0) ? 4  : (g == 1) ? 8 : (g == 2) ? 4  : 3;
    localparam int NS = W / SW;

    logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    logic         dir_en, dir_cout, dir_ovf;
    logic [W-1:0] dir_s;
    exp_t         q[$];
    int           beats_out = 0;
    bit           blk_done;
    bit           stop_or;

    pipelined_vector_adder #(.WIDTH(W), .SEG_W(SW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .cout     (cout),
      .ovf      (ovf)
    );

    // Model: each beat ages once per advancing edge and is due at age NS-1.
    always @(negedge clk) begin
      logic exp_ov, adv;
      logic [33:0] r;
      exp_t e;
      if (!rst_n) begin
        chk($sformatf("cfg%0d out_valid_in_reset", g), 32'(out_valid), 32'd0);
        q.delete();
      end else begin
        exp_ov = (q.size() > 0) && (q[0].age == NS - 1);
        adv    = !exp_ov || out_ready;
        chk($sformatf("cfg%0d out_valid", g), 32'(out_valid), 32'(exp_ov));
        chk($sformatf("cfg%0d in_ready", g), 32'(in_ready), 32'(adv));
        if (exp_ov && out_valid) begin
          chk($sformatf("cfg%0d s", g), 32'(s), q[0].s);
          chk($sformatf("cfg%0d cout", g), 32'(cout), 32'(q[0].cout));
          chk($sformatf("cfg%0d ovf", g), 32'(ovf), 32'(q[0].ovf));
        end
        if (exp_ov && out_ready) begin
          void'(q.pop_front());
          beats_out++;
        end
        if (adv) foreach (q[i]) q[i].age++;
        if (in_valid && adv) begin
          if (dir_en) begin
            e.s    = 32'(dir_s);
            e.cout = dir_cout;
            e.ovf  = dir_ovf;
          end else begin
            r      = ref_model(W, 32'(a), 32'(b), cin, sub);
            e.s    = r[31:0];
            e.cout = r[32];
            e.ovf  = r[33];
          end
          e.age = 0;
          q.push_back(e);
        end
      end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic ts, input logic de, input logic [W-1:0] ds,
                        input logic dc, input logic dov);
      int guard;
      a = ta; b = tb; cin = tc; sub = ts;
      dir_en = de; dir_s = ds; dir_cout = dc; dir_ovf = dov;
      in_valid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!in_ready && guard < 100);
      chk($sformatf("cfg%0d accept_bound", g), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    endtask

    task automatic idle();
      in_valid = 1'b0;
      dir_en   = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
    endtask

    task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    if (g == 0) begin : g_directed
      initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = ADD;
        out_ready = 1'b1; dir_en = 1'b0; dir_s = '0; dir_cout = 1'b0; dir_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("cfg0 reset_s", 32'(s), 32'd0);
        chk("cfg0 reset_cout", 32'(cout), 32'd0);
        chk("cfg0 reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cfg0 in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(16'h1234, 16'h4321, 1'b0, ADD, 1'b1, 16'h5555, 1'b0, 1'b0);
        idle();
        wait_cycles(8);

        send(16'hFFFF, 16'h0001, 1'b0, ADD, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, ADD, 1'b1, 16'h8000, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b1, SUB, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, SUB, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        idle();
        wait_cycles(8);

        fork
          begin
            for (int i = 0; i < 8; i++)
              send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'b0, '0, 1'b0, 1'b0);
            idle();
          end
          begin
            wait_cycles(5);
            out_ready = 1'b0;
            wait_cycles(5);
            out_ready = 1'b1;
          end
        join
        wait_cycles(16);
        chk("cfg0 backpressure_drained", 32'(q.size()), 32'd0);

        for (int i = 0; i < 3; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
               1'b0, '0, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("cfg0 mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("cfg0 mid_reset_s", 32'(s), 32'd0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(12);
        chk("cfg0 post_reset_empty", 32'(q.size()), 32'd0);
        blk_done = 1'b1;
      end
    end else begin : g_random
      initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = ADD;
        out_ready = 1'b0; dir_en = 1'b0; dir_s = '0; dir_cout = 1'b0; dir_ovf = 1'b0;
        stop_or = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
          begin
            for (int i = 0; i < 1000; i++) begin
              if ($urandom_range(0, 3) == 0) begin
                idle();
                wait_cycles(int'($urandom_range(1, 3)));
              end
              send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'b0, '0, 1'b0, 1'b0);
            end
            idle();
            stop_or = 1'b1;
          end
          begin
            while (!stop_or) begin
              out_ready = ($urandom_range(0, 3) != 0);
              @(posedge clk);
              #1;
            end
            out_ready = 1'b1;
          end
        join
        wait_cycles(2 * NS + 10);
        chk($sformatf("cfg%0d drained", g), 32'(q.size()), 32'd0);
        chk($sformatf("cfg%0d beat_count", g), 32'(beats_out), 32'd1000);
        blk_done = 1'b1;
      end
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done &&
             g_cfg[3].blk_done) && guard < 50000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_blocks_done",
        32'({g_cfg[3].blk_done, g_cfg[2].blk_done, g_cfg[1].blk_done, g_cfg[0].blk_done}),
        32'hF);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
